// File: rtl/mem_bus_pkg.sv
// Shared types and the default four-region memory map for the data-port bus decoder.
// Region order is RAM, UART, GPIO, ROM; region 0 sits in the low bits of each packed map.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } bus_state_e;

   localparam logic [31:0] RAM_BASE   = 32'h7FFF_EEFC;
   localparam logic [31:0] RAM_LIMIT  = 32'h7FFF_FFFF;
   localparam logic [31:0] UART_BASE  = 32'h1001_002C;
   localparam logic [31:0] UART_LIMIT = 32'h1001_003F;
   localparam logic [31:0] GPIO_BASE  = 32'h1001_0024;
   localparam logic [31:0] GPIO_LIMIT = 32'h1001_002B;
   localparam logic [31:0] ROM_BASE   = 32'h0040_0000;
   localparam logic [31:0] ROM_LIMIT  = 32'h004F_FFFF;

   localparam logic [127:0] DEFAULT_REGION_BASE  = {ROM_BASE, GPIO_BASE, UART_BASE, RAM_BASE};
   localparam logic [127:0] DEFAULT_REGION_LIMIT = {ROM_LIMIT, GPIO_LIMIT, UART_LIMIT, RAM_LIMIT};

   // Width of a region index; kept at least 1 so a single-region map still has a legal type.
   function automatic int unsigned idx_width(input int unsigned num_slaves);
      return (num_slaves > 1) ? $clog2(num_slaves) : 1;
   endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decoder: matches an address against the packed base/limit windows,
// returning the winning region, its region-relative offset and whether it is read-only.
module mem_region_decode
   import mem_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NUM_SLAVES = 4,
   parameter int unsigned IDX_W = idx_width(NUM_SLAVES),
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_BASE = DEFAULT_REGION_BASE,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_LIMIT = DEFAULT_REGION_LIMIT,
   parameter logic [NUM_SLAVES-1:0] READ_ONLY = '0
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  hit,
   output logic [IDX_W-1:0]      hit_idx,
   output logic [ADDR_WIDTH-1:0] offset,
   output logic                  ro_hit
);

   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH-1:0] limit;

   // Scan from the top down so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      offset  = '0;
      ro_hit  = 1'b0;
      base    = '0;
      limit   = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         base  = REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
         limit = REGION_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH];
         if ((addr >= base) && (addr <= limit)) begin
            hit     = 1'b1;
            hit_idx = i[IDX_W-1:0];
            offset  = addr - base;
            ro_hit  = READ_ONLY[i];
         end
      end
   end

endmodule

// File: rtl/mem_bus_decoder.sv
// Registered memory-map decoder between the core data port and NUM_SLAVES slaves:
// one request in flight, wait states with timeout, error on unmapped or read-only writes.
module mem_bus_decoder
   import mem_bus_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NUM_SLAVES = 4,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_BASE = DEFAULT_REGION_BASE,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_LIMIT = DEFAULT_REGION_LIMIT,
   parameter logic [NUM_SLAVES-1:0] READ_ONLY = '0,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             m_valid,
   output logic                             m_ready,
   input  logic                             m_wr,
   input  logic [ADDR_WIDTH-1:0]            m_addr,
   input  logic [DATA_WIDTH-1:0]            m_wdata,
   output logic                             m_rvalid,
   output logic [DATA_WIDTH-1:0]            m_rdata,
   output logic                             m_err,
   output logic [NUM_SLAVES-1:0]            s_sel,
   output logic                             s_wr,
   output logic [ADDR_WIDTH-1:0]            s_addr,
   output logic [DATA_WIDTH-1:0]            s_wdata,
   input  logic [NUM_SLAVES-1:0]            s_ready,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata
);

   localparam int unsigned IDX_W = idx_width(NUM_SLAVES);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   bus_state_e state_q, state_d;
   logic [NUM_SLAVES-1:0] sel_q, sel_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  dec_hit;
   logic [IDX_W-1:0]      dec_idx;
   logic [ADDR_WIDTH-1:0] dec_offset;
   logic                  dec_ro;
   logic                  sel_ready;
   logic [DATA_WIDTH-1:0] sel_rdata;

   mem_region_decode #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .NUM_SLAVES  (NUM_SLAVES),
      .IDX_W       (IDX_W),
      .REGION_BASE (REGION_BASE),
      .REGION_LIMIT(REGION_LIMIT),
      .READ_ONLY   (READ_ONLY)
   ) u_decode (
      .addr   (m_addr),
      .hit    (dec_hit),
      .hit_idx(dec_idx),
      .offset (dec_offset),
      .ro_hit (dec_ro)
   );

   // The one-hot select doubles as the response mux control and masks foreign ready bits.
   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q[i]) begin
            sel_rdata = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      sel_ready = |(s_ready & sel_q);
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (m_valid) begin
               addr_d  = dec_offset;
               wdata_d = m_wdata;
               if (!dec_hit || (m_wr && dec_ro)) begin
                  state_d = StResp;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = StAccess;
                  wr_d    = m_wr;
                  cnt_d   = '0;
                  for (int i = 0; i < NUM_SLAVES; i++) begin
                     sel_d[i] = (dec_idx == IDX_W'(i));
                  end
               end
            end
         end
         StAccess: begin
            if (sel_ready) begin
               state_d = StResp;
               err_d   = 1'b0;
               rdata_d = wr_q ? '0 : sel_rdata;
               sel_d   = '0;
               wr_d    = 1'b0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = StResp;
               err_d   = 1'b1;
               rdata_d = '0;
               sel_d   = '0;
               wr_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         sel_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign m_ready  = (state_q == StIdle);
   assign m_rvalid = (state_q == StResp);
   assign m_rdata  = rdata_q;
   assign m_err    = err_q;
   assign s_sel    = sel_q;
   assign s_wr     = wr_q;
   assign s_addr   = addr_q;
   assign s_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed bench for mem_bus_decoder: table of single transactions plus a reset-abort sequence.
module tb_mem_bus_decoder;

   logic         clk = 1'b0;
   logic         reset;
   logic         m_valid;
   logic         m_ready;
   logic         m_wr;
   logic [31:0]  m_addr;
   logic [31:0]  m_wdata;
   logic         m_rvalid;
   logic [31:0]  m_rdata;
   logic         m_err;
   logic [3:0]   s_sel;
   logic         s_wr;
   logic [31:0]  s_addr;
   logic [31:0]  s_wdata;
   logic [3:0]   s_ready;
   logic [127:0] s_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   mem_bus_decoder #(
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (32),
      .NUM_SLAVES    (4),
      .READ_ONLY     (4'b1000),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_wr    (m_wr),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rvalid(m_rvalid),
      .m_rdata (m_rdata),
      .m_err   (m_err),
      .s_sel   (s_sel),
      .s_wr    (s_wr),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_ready (s_ready),
      .s_rdata (s_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          delay;     // ACCESS edges before ready; -1 = never
      logic [31:0] sdata;
      logic [3:0]  noise;     // ready bits driven on unselected slaves
      logic        rej;
      logic [3:0]  exp_sel;
      logic [31:0] exp_saddr;
      int          exp_edges; // ACCESS edges until m_rvalid
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int   edges;
      logic sel_ok;
      logic done;
      check("idle_ready", 64'(m_ready), 64'd1);
      m_valid = 1'b1;
      m_wr    = v.wr;
      m_addr  = v.addr;
      m_wdata = v.wdata;
      for (int i = 0; i < 4; i++) begin
         s_rdata[i*32 +: 32] = v.exp_sel[i] ? v.sdata : (32'hDEAD_0000 | 32'(i));
      end
      s_ready = v.noise;
      step();
      m_valid = 1'b0;
      if (v.rej) begin
         check("rej_no_sel", 64'(s_sel), 64'd0);
         check("rej_rvalid_n1", 64'(m_rvalid), 64'd1);
      end else begin
         check("acc_sel", 64'(s_sel), 64'(v.exp_sel));
         check("acc_saddr", 64'(s_addr), 64'(v.exp_saddr));
         check("acc_swr", 64'(s_wr), 64'(v.wr));
         if (v.wr) check("acc_swdata", 64'(s_wdata), 64'(v.wdata));
         check("acc_not_ready", 64'(m_ready), 64'd0);
         edges  = 0;
         sel_ok = 1'b1;
         done   = 1'b0;
         while (!done && edges < 40) begin
            s_ready = v.noise | ((edges == v.delay) ? v.exp_sel : 4'b0000);
            step();
            edges++;
            if (m_rvalid) done = 1'b1;
            else if (s_sel !== v.exp_sel) sel_ok = 1'b0;
         end
         s_ready = 4'b0000;
         check("rsp_latency", 64'(edges), 64'(v.exp_edges));
         check("sel_held", 64'(sel_ok), 64'd1);
         check("sel_dropped", 64'(s_sel), 64'd0);
      end
      s_ready = 4'b0000;
      check("rsp_err", 64'(m_err), 64'(v.exp_err));
      check("rsp_rdata", 64'(m_rdata), 64'(v.exp_rdata));
      step();
      check("rvalid_one_cycle", 64'(m_rvalid), 64'd0);
      check("back_to_idle", 64'(m_ready), 64'd1);
      check("rdata_hold", 64'(m_rdata), 64'(v.exp_rdata));
      check("err_hold", 64'(m_err), 64'(v.exp_err));
   endtask

   initial begin
      logic seen_rvalid;
      // wr addr wdata delay sdata noise rej sel saddr edges err rdata
      vecs[0]  = '{1'b0, 32'h1001_0028, 32'h0,    0, 32'hA5A5_0001, 4'b0000, 1'b0,
                   4'b0100, 32'h4,    1,  1'b0, 32'hA5A5_0001};
      vecs[1]  = '{1'b1, 32'h7FFF_EF00, 32'h1234, 0, 32'hFFFF_FFFF, 4'b0000, 1'b0,
                   4'b0001, 32'h4,    1,  1'b0, 32'h0};
      vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,    0, 32'h0,         4'b0000, 1'b1,
                   4'b0000, 32'h0,    0,  1'b1, 32'h0};
      vecs[3]  = '{1'b1, 32'h0040_0100, 32'h55,   0, 32'h0,         4'b0000, 1'b1,
                   4'b0000, 32'h0,    0,  1'b1, 32'h0};
      vecs[4]  = '{1'b0, 32'h0040_0100, 32'h0,    2, 32'hC0DE_0003, 4'b0111, 1'b0,
                   4'b1000, 32'h100,  3,  1'b0, 32'hC0DE_0003};
      vecs[5]  = '{1'b0, 32'h1001_002C, 32'h0,    1, 32'h0BAD_F00D, 4'b0000, 1'b0,
                   4'b0010, 32'h0,    2,  1'b0, 32'h0BAD_F00D};
      vecs[6]  = '{1'b0, 32'h1001_002B, 32'h0,    0, 32'h0000_0077, 4'b0000, 1'b0,
                   4'b0100, 32'h7,    1,  1'b0, 32'h0000_0077};
      vecs[7]  = '{1'b0, 32'h7FFF_FFFF, 32'h0,   -1, 32'h1111_2222, 4'b1110, 1'b0,
                   4'b0001, 32'h1103, 16, 1'b1, 32'h0};
      vecs[8]  = '{1'b0, 32'h1001_0030, 32'h0,   15, 32'h3333_4444, 4'b0000, 1'b0,
                   4'b0010, 32'h4,    16, 1'b0, 32'h3333_4444};
      vecs[9]  = '{1'b0, 32'h1001_0023, 32'h0,    0, 32'h0,         4'b0000, 1'b1,
                   4'b0000, 32'h0,    0,  1'b1, 32'h0};
      vecs[10] = '{1'b1, 32'h8000_0000, 32'h9,    0, 32'h0,         4'b0000, 1'b1,
                   4'b0000, 32'h0,    0,  1'b1, 32'h0};

      reset   = 1'b0;
      m_valid = 1'b0;
      m_wr    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      s_ready = '0;
      s_rdata = '0;
      #12;
      check("rst_m_ready", 64'(m_ready), 64'd1);
      check("rst_m_rvalid", 64'(m_rvalid), 64'd0);
      check("rst_s_sel", 64'(s_sel), 64'd0);
      check("rst_m_rdata", 64'(m_rdata), 64'd0);
      check("rst_s_addr", 64'(s_addr), 64'd0);
      check("rst_m_err", 64'(m_err), 64'd0);
      step();
      reset = 1'b1;
      step();

      for (int k = 0; k < 11; k++) begin
         run_vec(vecs[k]);
         step();
      end

      // Reset asserted mid-ACCESS must drop the select at once and never answer.
      m_valid = 1'b1;
      m_wr    = 1'b1;
      m_addr  = 32'h7FFF_EF00;
      m_wdata = 32'hCAFE;
      s_ready = 4'b0000;
      step();
      m_valid = 1'b0;
      check("abort_sel_before", 64'(s_sel), 64'd1);
      step();
      step();
      reset = 1'b0;
      #1;
      check("abort_sel_async", 64'(s_sel), 64'd0);
      check("abort_swr_async", 64'(s_wr), 64'd0);
      step();
      reset = 1'b1;
      seen_rvalid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (m_rvalid) seen_rvalid = 1'b1;
      end
      check("abort_no_resp", 64'(seen_rvalid), 64'd0);
      check("abort_m_ready", 64'(m_ready), 64'd1);
      check("abort_s_addr", 64'(s_addr), 64'd0);
      check("abort_s_wdata", 64'(s_wdata), 64'd0);
      check("abort_m_err", 64'(m_err), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
